// File: rtl/mmio_periph_unit_pkg.sv
// Shared definitions for the MMIO peripheral unit: register map, TCON bits,
// register select encoding and the active-low seven-segment glyph table.
package mmio_periph_unit_pkg;

  localparam logic [4:0] OFF_TH      = 5'h00;
  localparam logic [4:0] OFF_TL      = 5'h04;
  localparam logic [4:0] OFF_TCON    = 5'h08;
  localparam logic [4:0] OFF_LED     = 5'h0C;
  localparam logic [4:0] OFF_DIGI    = 5'h10;
  localparam logic [4:0] OFF_SYSTICK = 5'h14;

  localparam int unsigned TCON_EN = 0;
  localparam int unsigned TCON_IE = 1;
  localparam int unsigned TCON_ST = 2;

  typedef enum logic [2:0] {
    SEL_TH,
    SEL_TL,
    SEL_TCON,
    SEL_LED,
    SEL_DIGI,
    SEL_SYSTICK,
    SEL_NONE
  } reg_sel_e;

  // {g,f,e,d,c,b,a}, active-low; entry n is the glyph for hex digit n
  localparam logic [15:0][6:0] SEG7_LUT = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,  // F E d C
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,  // b A 9 8
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,  // 7 6 5 4
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000   // 3 2 1 0
  };

  function automatic reg_sel_e decode_off(input logic [31:0] off);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (off[31:5] == '0) begin
      case ({off[4:2], 2'b00})
        OFF_TH:      sel = SEL_TH;
        OFF_TL:      sel = SEL_TL;
        OFF_TCON:    sel = SEL_TCON;
        OFF_LED:     sel = SEL_LED;
        OFF_DIGI:    sel = SEL_DIGI;
        OFF_SYSTICK: sel = SEL_SYSTICK;
        default:     sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/mmio_periph_unit_if.sv
// Data-memory bus as seen from the MEM stage: address, store data, strobes,
// combinational read data and hit.
interface mmio_periph_unit_if;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Read_data;
  logic        hit;

  modport master (
    output Address, Write_data, MemWrite, MemRead,
    input  Read_data, hit
  );

  modport slave (
    input  Address, Write_data, MemWrite, MemRead,
    output Read_data, hit
  );
endinterface

// File: rtl/mmio_periph_unit_hex_to_seg7.sv
// Combinational hex nibble to active-low {g,f,e,d,c,b,a} segment decoder.
module hex_to_seg7
  import mmio_periph_unit_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = SEG7_LUT[hex];
endmodule

// File: rtl/mmio_periph_unit.sv
// Memory-mapped peripheral unit: reload timer with irq, LED register,
// free-running systick and a 4-digit multiplexed 7-segment hex display.
module mmio_periph_unit
  import mmio_periph_unit_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic                clk,
  input  logic                reset,
  mmio_periph_unit_if.slave   bus,
  output logic                irq,
  output logic [7:0]          led,
  output logic [6:0]          Seg,
  output logic [3:0]          Ano
);

  localparam int unsigned CW = $clog2(SCAN_DIV);

  logic [31:0]   th, tl, systick;
  logic [2:0]    tcon;
  logic [15:0]   digi;
  logic [CW-1:0] scan_cnt;
  logic [1:0]    idx, idx_next;
  logic [6:0]    seg_next;
  reg_sel_e      sel;
  logic          wr_en, scan_tc, tl_wrap;

  assign sel      = decode_off(bus.Address - BASE_ADDR);
  assign bus.hit  = (sel != SEL_NONE);
  assign wr_en    = bus.MemWrite && bus.hit;
  assign scan_tc  = (scan_cnt == CW'(SCAN_DIV - 1));
  assign idx_next = idx + 2'd1;
  assign tl_wrap  = (tl == '1);

  always_comb begin
    bus.Read_data = '0;
    if (bus.MemRead && bus.hit) begin
      case (sel)
        SEL_TH:      bus.Read_data = th;
        SEL_TL:      bus.Read_data = tl;
        SEL_TCON:    bus.Read_data = {29'd0, tcon};
        SEL_LED:     bus.Read_data = {24'd0, led};
        SEL_DIGI:    bus.Read_data = {16'd0, digi};
        SEL_SYSTICK: bus.Read_data = systick;
        default:     bus.Read_data = '0;
      endcase
    end
  end

  // A bus write to TL or TCON overrides the timer update of that register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
      irq  <= 1'b0;
    end else begin
      irq <= tcon[TCON_ST] & tcon[TCON_IE];
      if (wr_en && sel == SEL_TH) th <= bus.Write_data;
      if (wr_en && sel == SEL_TL) tl <= bus.Write_data;
      else if (tcon[TCON_EN])     tl <= tl_wrap ? th : tl + 32'd1;
      if (wr_en && sel == SEL_TCON)
        tcon <= bus.Write_data[2:0];
      else if (tcon[TCON_EN] && tl_wrap && tcon[TCON_IE])
        tcon[TCON_ST] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led     <= '0;
      digi    <= '0;
      systick <= '0;
    end else begin
      systick <= systick + 32'd1;
      if (wr_en && sel == SEL_LED)  led  <= bus.Write_data[7:0];
      if (wr_en && sel == SEL_DIGI) digi <= bus.Write_data[15:0];
    end
  end

  hex_to_seg7 u_hex_to_seg7 (
    .hex (digi[{idx_next, 2'b00} +: 4]),
    .seg (seg_next)
  );

  // Ano and Seg are reloaded together only when the digit index advances
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      idx      <= '0;
      Ano      <= 4'b1110;
      Seg      <= 7'b1000000;
    end else if (scan_tc) begin
      scan_cnt <= '0;
      idx      <= idx_next;
      Ano      <= ~(4'b0001 << idx_next);
      Seg      <= seg_next;
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_mmio_periph_unit.sv
// Directed scoreboard bench for mmio_periph_unit with a short scan divider.
module tb_mmio_periph_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       irq;
  logic [7:0] led;
  logic [6:0] Seg;
  logic [3:0] Ano;

  mmio_periph_unit_if bus();

  mmio_periph_unit #(
    .SCAN_DIV  (4),
    .BASE_ADDR (32'h4000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .irq   (irq),
    .led   (led),
    .Seg   (Seg),
    .Ano   (Ano)
  );

  always #10 clk = ~clk;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_DIGI = 32'h4000_0010;
  localparam logic [31:0] A_TICK = 32'h4000_0014;
  localparam logic [31:0] A_BAD  = 32'h4000_0018;

  // Edges since reset release: models SYSTICK and the scan phase
  int unsigned ncyc;
  always @(posedge clk or posedge reset)
    if (reset) ncyc <= 0;
    else       ncyc <= ncyc + 1;

  int          checks = 0;
  int          errors = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  task automatic expect_v(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic observe(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.Address    = a;
    bus.Write_data = d;
    bus.MemWrite   = 1'b1;
    @(posedge clk);
    #1;
    bus.MemWrite   = 1'b0;
  endtask

  task automatic check_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    expect_v(tag, exp);
    bus.Address = a;
    bus.MemRead = 1'b1;
    #1;
    observe(bus.Read_data);
    bus.MemRead = 1'b0;
  endtask

  task automatic check_hit(input string tag, input logic [31:0] a, input logic exp);
    expect_v(tag, {31'd0, exp});
    bus.Address = a;
    #1;
    observe({31'd0, bus.hit});
  endtask

  task automatic check_outs(input string tag, input logic [7:0] e_led, input logic [3:0] e_ano,
                            input logic [6:0] e_seg, input logic e_irq);
    expect_v({tag, "_led"}, {24'd0, e_led});
    expect_v({tag, "_ano"}, {28'd0, e_ano});
    expect_v({tag, "_seg"}, {25'd0, e_seg});
    expect_v({tag, "_irq"}, {31'd0, e_irq});
    observe({24'd0, led});
    observe({28'd0, Ano});
    observe({25'd0, Seg});
    observe({31'd0, irq});
  endtask

  task automatic check_irq(input string tag, input logic exp);
    expect_v(tag, {31'd0, exp});
    observe({31'd0, irq});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] seg_ref [4];
    int unsigned d;
    seg_ref[0] = 7'b0001110;  // F
    seg_ref[1] = 7'b0001000;  // A
    seg_ref[2] = 7'b0100100;  // 2
    seg_ref[3] = 7'b1111001;  // 1

    bus.Address = '0; bus.Write_data = '0; bus.MemWrite = 1'b0; bus.MemRead = 1'b0;
    #1 reset = 1'b1;
    #1 check_outs("rst", 8'h00, 4'b1110, 7'b1000000, 1'b0);
    tick(2);
    reset = 1'b0;

    check_read("rst_th",   A_TH,   32'h0);
    check_read("rst_tl",   A_TL,   32'h0);
    check_read("rst_tcon", A_TCON, 32'h0);
    check_read("rst_led",  A_LED,  32'h0);
    check_read("rst_digi", A_DIGI, 32'h0);
    check_read("rst_tick", A_TICK, 32'h0);
    check_hit("hit_tick", A_TICK, 1'b1);
    tick(2);
    check_read("tick_2", A_TICK, 32'd2);

    // Reload timer with interrupt
    bus_write(A_TH, 32'hFFFF_FFFD);
    bus_write(A_TL, 32'hFFFF_FFFE);
    bus_write(A_TCON, 32'd3);
    check_read("tl_start", A_TL, 32'hFFFF_FFFE);
    check_read("tcon_start", A_TCON, 32'd3);
    tick(1);
    check_read("tl_max", A_TL, 32'hFFFF_FFFF);
    check_irq("irq_pre", 1'b0);
    tick(1);
    check_read("tl_reload", A_TL, 32'hFFFF_FFFD);
    check_read("tcon_status", A_TCON, 32'd7);
    check_irq("irq_same", 1'b0);
    tick(1);
    check_irq("irq_set", 1'b1);
    bus_write(A_TCON, 32'd3);
    check_read("tcon_clr", A_TCON, 32'd3);
    check_irq("irq_hold", 1'b1);
    tick(1);
    check_irq("irq_drop", 1'b0);
    bus_write(A_TCON, 32'd0);
    tick(1);
    check_irq("irq_off", 1'b0);

    // Bus write beats timer update on the same register
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_write(A_TCON, 32'd1);
    check_read("tl_held", A_TL, 32'hFFFF_FFFF);
    bus_write(A_TL, 32'd5);
    check_read("tl_wr_wins", A_TL, 32'd5);
    check_read("tcon_no_st", A_TCON, 32'd1);
    tick(1);
    check_read("tl_inc", A_TL, 32'd6);
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_write(A_TCON, 32'd3);
    check_read("tl_wrap_wr", A_TL, 32'hFFFF_FFFD);
    check_read("tcon_wr_wins", A_TCON, 32'd3);
    bus_write(A_TCON, 32'd0);

    // Display scan
    bus_write(A_DIGI, 32'h0000_12AF);
    check_read("digi", A_DIGI, 32'h0000_12AF);
    tick(1);
    for (int k = 0; k < 8 && (ncyc % 4) != 0; k++) tick(1);
    for (int s = 0; s < 8; s++) begin
      d = (ncyc / 4) % 4;
      expect_v("scan_ano", {28'd0, ~(4'b0001 << d)});
      expect_v("scan_seg", {25'd0, seg_ref[d]});
      observe({28'd0, Ano});
      observe({25'd0, Seg});
      tick(2);
      expect_v("scan_ano_mid", {28'd0, ~(4'b0001 << d)});
      observe({28'd0, Ano});
      tick(2);
    end

    // LED, unmapped accesses, read-only SYSTICK
    bus_write(A_LED, 32'h0000_01A5);
    expect_v("led_port", 32'h0000_00A5);
    observe({24'd0, led});
    check_read("led_rd", A_LED, 32'h0000_00A5);
    check_hit("hit_bad", A_BAD, 1'b0);
    check_hit("hit_below", 32'h3FFF_FFFC, 1'b0);
    check_hit("hit_bytes", 32'h4000_000F, 1'b1);
    check_read("rd_bad", A_BAD, 32'h0);
    bus_write(A_BAD, 32'h0000_00FF);
    check_read("led_unmapped", A_LED, 32'h0000_00A5);
    bus.Address = A_LED;
    bus.MemRead = 1'b0;
    expect_v("rd_noread", 32'h0);
    #1 observe(bus.Read_data);
    bus_write(A_TICK, 32'h0);
    check_read("tick_ro", A_TICK, ncyc);

    // Asynchronous reset mid-operation
    bus_write(A_DIGI, 32'h0000_1234);
    bus_write(A_TCON, 32'd7);
    tick(2);
    check_irq("irq_pre_rst", 1'b1);
    #3 reset = 1'b1;
    #1 check_outs("async_rst", 8'h00, 4'b1110, 7'b1000000, 1'b0);
    check_read("async_tcon", A_TCON, 32'h0);
    check_read("async_digi", A_DIGI, 32'h0);
    tick(1);
    reset = 1'b0;
    tick(2);
    check_read("tl_stopped", A_TL, 32'h0);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
